// File: rtl/occamy_regbus_arbiter.sv
// occamy_regbus_arbiter
// Round-robin arbiter sharing one 32-bit regbus target between NumReq
// requesters. A grant is held until its transaction completes, then the
// priority pointer advances past the granted requester.
// Optional watchdog: define OCCAMY_REGBUS_ARB_TIMEOUT_EN to build it. The
// watchdog answers with an error when the target stalls for TimeoutCycles
// BUSY cycles. Without the macro, BUSY waits indefinitely.
module occamy_regbus_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               req_valid_i,
  input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq-1:0]               req_write_i,
  input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
  input  logic [NumReq*DataWidth/8-1:0]   req_wstrb_i,
  output logic [NumReq-1:0]               req_ready_o,
  output logic [DataWidth-1:0]            req_rdata_o,
  output logic                            req_error_o,
  output logic                            tgt_valid_o,
  output logic [AddrWidth-1:0]            tgt_addr_o,
  output logic                            tgt_write_o,
  output logic [DataWidth-1:0]            tgt_wdata_o,
  output logic [DataWidth/8-1:0]          tgt_wstrb_o,
  input  logic                            tgt_ready_i,
  input  logic [DataWidth-1:0]            tgt_rdata_i,
  input  logic                            tgt_error_i,
  output logic [$clog2(NumReq)-1:0]       gnt_idx_o,
  output logic                            busy_o,
  output logic                            timeout_o
);

  localparam int unsigned IdxW  = $clog2(NumReq);
  localparam int unsigned StrbW = DataWidth / 8;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_ptr_next;
  logic [IdxW-1:0] r_gnt;
  logic [IdxW-1:0] w_gnt_next;
  logic [IdxW-1:0] w_pick;
  logic [IdxW-1:0] w_gnt_inc;
  logic            w_any_valid;
  logic            w_busy;
  logic            w_gnt_valid;
  logic            w_handshake;
  logic            w_timeout;
  logic            w_enter_busy;

  // Reject configurations the arbiter cannot support.
  if (NumReq < 2 || TimeoutCycles < 2) begin : g_bad_cfg
    $error("occamy_regbus_arbiter: NumReq and TimeoutCycles must both be >= 2");
  end

  // (base + off) mod NumReq; base < NumReq and off < NumReq, so one wrap suffices.
  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base,
                                             input int unsigned   off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NumReq) sum = sum - NumReq;
    return IdxW'(sum);
  endfunction

  assign w_busy      = (r_state == ST_BUSY);
  assign w_gnt_valid = req_valid_i[r_gnt];
  assign w_handshake = w_busy & w_gnt_valid & tgt_ready_i;
  assign w_gnt_inc   = rr_idx(r_gnt, 1);

  // Pick the first valid requester at or after the priority pointer.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    w_any_valid = 1'b0;
    w_pick      = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!w_any_valid && req_valid_i[rr_idx(r_ptr, k)]) begin
        w_any_valid = 1'b1;
        w_pick      = rr_idx(r_ptr, k);
      end
    end
  end

`ifdef OCCAMY_REGBUS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] r_wdog_cnt;

  // Count BUSY cycles without a handshake; restart on every new grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wdog_cnt <= '0;
    end else if (w_enter_busy) begin
      r_wdog_cnt <= '0;
    end else if (w_busy && !w_handshake) begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end
  end

  // A handshake in the firing cycle wins over the watchdog.
  assign w_timeout = w_busy & w_gnt_valid & ~tgt_ready_i &
                     (r_wdog_cnt == CntW'(TimeoutCycles - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state logic: grant from IDLE, release on handshake, drop or timeout.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_gnt_next   = r_gnt;
    w_enter_busy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_next = ST_BUSY;
          w_gnt_next   = w_pick;
          w_enter_busy = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_handshake || !w_gnt_valid || w_timeout) begin
          w_state_next = ST_IDLE;
          w_ptr_next   = w_gnt_inc;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_gnt   <= w_gnt_next;
    end
  end

  // Response path: only the granted requester sees ready; data is zero otherwise.
  always_comb begin
    req_ready_o = '0;
    req_rdata_o = '0;
    req_error_o = 1'b0;
    if (w_handshake) begin
      req_ready_o[r_gnt] = 1'b1;
      req_rdata_o        = tgt_rdata_i;
      req_error_o        = tgt_error_i;
    end else if (w_timeout) begin
      req_ready_o[r_gnt] = 1'b1;
      req_error_o        = 1'b1;
    end
  end

  // Request path: live mux of the granted slice, forced to zero outside BUSY.
  assign tgt_valid_o = w_busy & w_gnt_valid;
  assign tgt_addr_o  = w_busy ? req_addr_i[r_gnt*AddrWidth +: AddrWidth] : '0;
  assign tgt_write_o = w_busy & req_write_i[r_gnt];
  assign tgt_wdata_o = w_busy ? req_wdata_i[r_gnt*DataWidth +: DataWidth] : '0;
  assign tgt_wstrb_o = w_busy ? req_wstrb_i[r_gnt*StrbW +: StrbW] : '0;

  assign gnt_idx_o = r_gnt;
  assign busy_o    = w_busy;
  assign timeout_o = w_timeout;

endmodule

// File: tb/tb_occamy_regbus_arbiter.sv
// tb_occamy_regbus_arbiter
// Directed bench for occamy_regbus_arbiter. The target is modelled as
// combinational: it answers in the same cycle tgt_valid_o is high, gated by
// tb_ready. Inputs change 2 time units after a rising edge, outputs are
// sampled 1 unit later. Define OCCAMY_REGBUS_ARB_TIMEOUT_EN to exercise the
// watchdog with TimeoutCycles = 8.
module tb_occamy_regbus_arbiter;

  localparam int NumReq    = 4;
  localparam int AddrWidth = 48;
  localparam int DataWidth = 32;
`ifdef OCCAMY_REGBUS_ARB_TIMEOUT_EN
  localparam int TimeoutCycles = 8;
`else
  localparam int TimeoutCycles = 1024;
`endif

  logic                          clk = 1'b0;
  logic                          rst_i;
  logic [NumReq-1:0]             req_valid_i;
  logic [NumReq*AddrWidth-1:0]   req_addr_i;
  logic [NumReq-1:0]             req_write_i;
  logic [NumReq*DataWidth-1:0]   req_wdata_i;
  logic [NumReq*DataWidth/8-1:0] req_wstrb_i;
  logic [NumReq-1:0]             req_ready_o;
  logic [DataWidth-1:0]          req_rdata_o;
  logic                          req_error_o;
  logic                          tgt_valid_o;
  logic [AddrWidth-1:0]          tgt_addr_o;
  logic                          tgt_write_o;
  logic [DataWidth-1:0]          tgt_wdata_o;
  logic [DataWidth/8-1:0]        tgt_wstrb_o;
  logic                          tgt_ready_i;
  logic [DataWidth-1:0]          tgt_rdata_i;
  logic                          tgt_error_i;
  logic [1:0]                    gnt_idx_o;
  logic                          busy_o;
  logic                          timeout_o;

  logic                          tb_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign tgt_ready_i = tb_ready & tgt_valid_o;

  occamy_regbus_arbiter #(
    .NumReq       (NumReq),
    .AddrWidth    (AddrWidth),
    .DataWidth    (DataWidth),
    .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_addr_i (req_addr_i),
    .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i),
    .req_wstrb_i(req_wstrb_i),
    .req_ready_o(req_ready_o),
    .req_rdata_o(req_rdata_o),
    .req_error_o(req_error_o),
    .tgt_valid_o(tgt_valid_o),
    .tgt_addr_o (tgt_addr_o),
    .tgt_write_o(tgt_write_o),
    .tgt_wdata_o(tgt_wdata_o),
    .tgt_wstrb_o(tgt_wstrb_o),
    .tgt_ready_i(tgt_ready_i),
    .tgt_rdata_i(tgt_rdata_i),
    .tgt_error_i(tgt_error_i),
    .gnt_idx_o  (gnt_idx_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [47:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
    req_addr_i[i*AddrWidth +: AddrWidth] = a;
    req_write_i[i]                       = w;
    req_wdata_i[i*DataWidth +: DataWidth] = d;
    req_wstrb_i[i*4 +: 4]                = s;
  endtask

  int rr_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 4'b1111;
    req_addr_i  = '0;
    req_write_i = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    for (int i = 0; i < NumReq; i++)
      set_req(i, 48'h100 * (i + 1), 1'b1, 32'hA000_0000 + i, 4'hF);
    tb_ready    = 1'b1;
    tgt_rdata_i = 32'hCAFE_F00D;
    tgt_error_i = 1'b0;

    // Reset held for 3 cycles with every requester valid.
    repeat (3) tick();
    settle();
    check("rst_busy",      64'(busy_o),      64'(0));
    check("rst_gnt",       64'(gnt_idx_o),   64'(0));
    check("rst_timeout",   64'(timeout_o),   64'(0));
    check("rst_tgt_valid", 64'(tgt_valid_o), 64'(0));
    check("rst_tgt_addr",  64'(tgt_addr_o),  64'(0));
    check("rst_tgt_write", 64'(tgt_write_o), 64'(0));
    check("rst_tgt_wdata", 64'(tgt_wdata_o), 64'(0));
    check("rst_tgt_wstrb", 64'(tgt_wstrb_o), 64'(0));
    check("rst_ready",     64'(req_ready_o), 64'(0));
    check("rst_rdata",     64'(req_rdata_o), 64'(0));
    check("rst_error",     64'(req_error_o), 64'(0));
    rst_i = 1'b0;

    // Round robin: all valid, target always ready -> 0,1,2,3,0, two cycles each.
    for (int t = 0; t < 5; t++) begin
      tick();
      settle();
      check("rr_gnt",   64'(gnt_idx_o),   64'(rr_order[t]));
      check("rr_busy",  64'(busy_o),      64'(1));
      check("rr_ready", 64'(req_ready_o), 64'(4'b0001 << rr_order[t]));
      check("rr_rdata", 64'(req_rdata_o), 64'(32'hCAFE_F00D));
      tick();
      settle();
      check("rr_idle_busy",  64'(busy_o),      64'(0));
      check("rr_idle_ready", 64'(req_ready_o), 64'(0));
    end

    // Single read from requester 2 (pointer is 1 here).
    req_valid_i = 4'b0100;
    set_req(2, 48'h1000, 1'b0, 32'h0, 4'h0);
    tgt_rdata_i = 32'hDEAD_BEEF;
    settle();
    check("rd_idle_tgt_valid", 64'(tgt_valid_o), 64'(0));
    tick();
    settle();
    check("rd_gnt",       64'(gnt_idx_o),   64'(2));
    check("rd_tgt_valid", 64'(tgt_valid_o), 64'(1));
    check("rd_tgt_addr",  64'(tgt_addr_o),  64'(48'h1000));
    check("rd_tgt_write", 64'(tgt_write_o), 64'(0));
    check("rd_ready",     64'(req_ready_o), 64'(4'b0100));
    check("rd_rdata",     64'(req_rdata_o), 64'(32'hDEAD_BEEF));
    check("rd_error",     64'(req_error_o), 64'(0));
    tick();
    // Pointer must now be 3: with everyone valid, requester 3 wins.
    req_valid_i = 4'b1111;
    settle();
    check("rd_after_busy", 64'(busy_o), 64'(0));
    tick();
    settle();
    check("ptr3_gnt",   64'(gnt_idx_o),   64'(3));
    check("ptr3_ready", 64'(req_ready_o), 64'(4'b1000));
    tick();

    // Target stall: requester 1 writes, requester 3 waits; pointer wrapped to 0.
    req_valid_i = 4'b1010;
    set_req(1, 48'h2004, 1'b1, 32'h1234_5678, 4'hF);
    set_req(3, 48'h3008, 1'b0, 32'h0, 4'h0);
    tb_ready = 1'b0;
    tick();
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) tb_ready = 1'b1;
      settle();
      check("st_ready", 64'(req_ready_o), (c == 6) ? 64'(4'b0010) : 64'(0));
      if (c == 1 || c == 5) begin
        check("st_gnt",       64'(gnt_idx_o),   64'(1));
        check("st_tgt_valid", 64'(tgt_valid_o), 64'(1));
        check("st_tgt_addr",  64'(tgt_addr_o),  64'(48'h2004));
        check("st_tgt_write", 64'(tgt_write_o), 64'(1));
        check("st_tgt_wdata", 64'(tgt_wdata_o), 64'(32'h1234_5678));
        check("st_tgt_wstrb", 64'(tgt_wstrb_o), 64'(4'hF));
      end
      if (c < 6) tick();
    end
    req_valid_i = 4'b1000;
    tick();
    settle();
    check("st_after_ready", 64'(req_ready_o), 64'(0));
    check("st_after_busy",  64'(busy_o),      64'(0));
    tick();
    settle();
    check("wait3_gnt",   64'(gnt_idx_o),   64'(3));
    check("wait3_ready", 64'(req_ready_o), 64'(4'b1000));
    req_valid_i = 4'b0000;
    tick();

    // Watchdog: requester 0 reads, target never ready.
    req_valid_i = 4'b0001;
    set_req(0, 48'h40, 1'b0, 32'h0, 4'h0);
    tb_ready    = 1'b0;
    tgt_rdata_i = 32'h5555_AAAA;
    tick();
`ifdef OCCAMY_REGBUS_ARB_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      settle();
      check("wd_timeout", 64'(timeout_o),   (c == 8) ? 64'(1) : 64'(0));
      check("wd_ready",   64'(req_ready_o), (c == 8) ? 64'(4'b0001) : 64'(0));
      if (c == 8) begin
        check("wd_error", 64'(req_error_o), 64'(1));
        check("wd_rdata", 64'(req_rdata_o), 64'(0));
      end
      if (c < 8) tick();
    end
    req_valid_i = 4'b0000;
    tick();
    settle();
    check("wd_after_timeout",   64'(timeout_o),   64'(0));
    check("wd_after_busy",      64'(busy_o),      64'(0));
    check("wd_after_tgt_valid", 64'(tgt_valid_o), 64'(0));
`else
    begin
      int busy_cnt = 0;
      for (int c = 0; c < 101; c++) begin
        settle();
        if (busy_o && req_ready_o == 4'b0000 && timeout_o == 1'b0) busy_cnt++;
        tick();
      end
      check("nowd_busy_cycles", 64'(busy_cnt), 64'(101));
    end
    // Requester abandons: no response, back to IDLE.
    req_valid_i = 4'b0000;
    settle();
    check("drop_ready", 64'(req_ready_o), 64'(0));
    tick();
    settle();
    check("drop_busy", 64'(busy_o), 64'(0));
`endif

    // Reset during a stall: pointer is 1 here, requester 2 granted.
    req_valid_i = 4'b0100;
    set_req(2, 48'h5000, 1'b0, 32'h0, 4'h0);
    tb_ready = 1'b0;
    tick();
    settle();
    check("rb_gnt",       64'(gnt_idx_o),   64'(2));
    check("rb_tgt_valid", 64'(tgt_valid_o), 64'(1));
    tick();
    rst_i = 1'b1;
    settle();
    check("rb_ready_in_rst", 64'(req_ready_o), 64'(0));
    tick();
    settle();
    check("rb_tgt_valid_after", 64'(tgt_valid_o), 64'(0));
    check("rb_busy_after",      64'(busy_o),      64'(0));
    check("rb_ready_after",     64'(req_ready_o), 64'(0));
    rst_i       = 1'b0;
    req_valid_i = 4'b1111;
    tb_ready    = 1'b1;
    tick();
    settle();
    check("rb_ptr0_gnt",   64'(gnt_idx_o),   64'(0));
    check("rb_ptr0_ready", 64'(req_ready_o), 64'(4'b0001));
    req_valid_i = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
